// File: rtl/pwr_rail_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pwr_rail_ctrl
// Brief    : Power-init step responder; walks six rail enables one at a time
//            toward the filtered step target and confirms each via power-good.
//            Optional brownout monitor in STABLE: define PWR_BROWNOUT_MON_EN.
// Revision : 1.0
// ============================================================================
module pwr_rail_ctrl #(
  parameter int FILT_CYCLES = 4,
  parameter int DEB_CYCLES  = 16,
  parameter int UP_TIMEOUT  = 1000000,
  parameter int DN_TIMEOUT  = 1000000,
  parameter int ROIC_DLY    = 64,
  parameter int CNT_W       = 24
) (
  input  logic       fsm_clk,
  input  logic       rst_n,
  input  logic       pwr_init_step1,
  input  logic       pwr_init_step2,
  input  logic       pwr_init_step3,
  input  logic       pwr_init_step4,
  input  logic       pwr_init_step5,
  input  logic       pwr_init_step6,
  input  logic [5:0] pg_in,
  input  logic       clear_fault,
  output logic [5:0] rail_en,
  output logic       rails_ready,
  output logic       roic_rst_n,
  output logic       pwr_fault,
  output logic [2:0] fault_rail,
  output logic [2:0] level
);

  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [FW-1:0]    c_filt_last = FW'(FILT_CYCLES - 1);
  localparam logic [DW-1:0]    c_deb_last  = DW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_up_last   = CNT_W'(UP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_dn_last   = CNT_W'(DN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_roic_last = CNT_W'(ROIC_DLY - 1);

  typedef enum logic [1:0] {
    ST_STABLE  = 2'd0,
    ST_RAMP_UP = 2'd1,
    ST_RAMP_DN = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  state_t           r_state;
  logic [5:0]       r_step_s1, r_step_s2, r_pg_s1, r_pg_s2;
  logic [2:0]       r_cand, r_target, r_level, r_fault_rail;
  logic [FW-1:0]    r_filt_cnt;
  logic [DW-1:0]    r_deb_cnt;
  logic [CNT_W-1:0] r_tmo_cnt, r_roic_cnt;
  logic [5:0]       r_rail_en;
  logic             r_rails_ready, r_roic_rst_n, r_pwr_fault;

  logic [5:0] w_step_raw;
  logic [2:0] w_step_idx, w_dn_idx, w_fault_num, w_bo_rail;
  logic       w_pg_up, w_pg_dn, w_up_ok, w_dn_ok, w_fault_go, w_bo_fault;

  assign w_step_raw = {pwr_init_step6, pwr_init_step5, pwr_init_step4,
                       pwr_init_step3, pwr_init_step2, pwr_init_step1};

  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_s1 <= '0;
      r_step_s2 <= '0;
      r_pg_s1   <= '0;
      r_pg_s2   <= '0;
    end else begin
      r_step_s1 <= w_step_raw;
      r_step_s2 <= r_step_s1;
      r_pg_s1   <= pg_in;
      r_pg_s2   <= r_pg_s1;
    end
  end

  // Highest asserted step wins.
  always_comb begin
    w_step_idx = 3'd0;
    for (int k = 0; k < 6; k++) begin
      if (r_step_s2[k]) w_step_idx = 3'(k + 1);
    end
  end

  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand     <= 3'd0;
      r_filt_cnt <= '0;
      r_target   <= 3'd0;
    end else if (w_step_idx != r_cand) begin
      r_cand     <= w_step_idx;
      r_filt_cnt <= FW'(1);
      if (FILT_CYCLES <= 1) r_target <= w_step_idx;
    end else if (r_filt_cnt >= c_filt_last) begin
      r_target <= r_cand;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

`ifdef PWR_BROWNOUT_MON_EN
  logic [5:0] w_bo_hit;

  for (genvar k = 0; k < 6; k++) begin : g_bo
    logic [DW-1:0] r_bo_cnt;
    logic          w_low;

    assign w_low       = (r_state == ST_STABLE) && r_rail_en[k] && !r_pg_s2[k];
    assign w_bo_hit[k] = w_low && (r_bo_cnt == c_deb_last);

    always_ff @(posedge fsm_clk or negedge rst_n) begin
      if (!rst_n)                      r_bo_cnt <= '0;
      else if (!w_low)                 r_bo_cnt <= '0;
      else if (r_bo_cnt != c_deb_last) r_bo_cnt <= r_bo_cnt + 1'b1;
    end
  end

  always_comb begin
    w_bo_rail = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (w_bo_hit[k]) w_bo_rail = 3'(k + 1);
    end
  end
  assign w_bo_fault = |w_bo_hit;
`else
  assign w_bo_fault = 1'b0;
  assign w_bo_rail  = 3'd0;
`endif

  assign w_dn_idx = r_level - 3'd1;
  assign w_pg_up  = r_pg_s2[r_level];
  assign w_pg_dn  = r_pg_s2[w_dn_idx];
  assign w_up_ok  = w_pg_up && (r_deb_cnt == c_deb_last);
  assign w_dn_ok  = !w_pg_dn && (r_deb_cnt == c_deb_last);

  // Confirmation wins over a timeout landing in the same cycle.
  always_comb begin
    w_fault_go  = 1'b0;
    w_fault_num = 3'd0;
    case (r_state)
      ST_STABLE: begin
        w_fault_go  = w_bo_fault;
        w_fault_num = w_bo_rail;
      end
      ST_RAMP_UP: begin
        w_fault_go  = !w_up_ok && (r_tmo_cnt == c_up_last);
        w_fault_num = r_level + 3'd1;
      end
      ST_RAMP_DN: begin
        w_fault_go  = !w_dn_ok && (r_tmo_cnt == c_dn_last);
        w_fault_num = r_level;
      end
      default: begin
        w_fault_go  = 1'b0;
        w_fault_num = 3'd0;
      end
    endcase
  end

  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_STABLE;
      r_level       <= 3'd0;
      r_rail_en     <= '0;
      r_tmo_cnt     <= '0;
      r_deb_cnt     <= '0;
      r_roic_cnt    <= '0;
      r_rails_ready <= 1'b0;
      r_roic_rst_n  <= 1'b0;
      r_pwr_fault   <= 1'b0;
      r_fault_rail  <= 3'd0;
    end else begin
      if (!r_rails_ready) begin
        r_roic_cnt   <= '0;
        r_roic_rst_n <= 1'b0;
      end else if (!r_roic_rst_n) begin
        if (r_roic_cnt == c_roic_last) r_roic_rst_n <= 1'b1;
        else                           r_roic_cnt   <= r_roic_cnt + 1'b1;
      end

      case (r_state)
        ST_STABLE: begin
          if (r_target > r_level) begin
            r_rail_en[r_level] <= 1'b1;
            r_tmo_cnt          <= '0;
            r_deb_cnt          <= '0;
            r_state            <= ST_RAMP_UP;
          end else if (r_target < r_level) begin
            r_rail_en[w_dn_idx] <= 1'b0;
            r_tmo_cnt           <= '0;
            r_deb_cnt           <= '0;
            r_rails_ready       <= 1'b0;
            r_roic_rst_n        <= 1'b0;
            r_roic_cnt          <= '0;
            r_state             <= ST_RAMP_DN;
          end
        end
        ST_RAMP_UP: begin
          if (w_up_ok) begin
            r_level       <= r_level + 3'd1;
            r_rails_ready <= (r_level == 3'd5);
            r_state       <= ST_STABLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            r_deb_cnt <= w_pg_up ? r_deb_cnt + 1'b1 : '0;
          end
        end
        ST_RAMP_DN: begin
          if (w_dn_ok) begin
            r_level <= r_level - 3'd1;
            r_state <= ST_STABLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            r_deb_cnt <= !w_pg_dn ? r_deb_cnt + 1'b1 : '0;
          end
        end
        ST_FAULT: begin
          if (clear_fault && (r_target == 3'd0)) begin
            r_pwr_fault  <= 1'b0;
            r_fault_rail <= 3'd0;
            r_state      <= ST_STABLE;
          end
        end
        default: r_state <= ST_STABLE;
      endcase

      // Fault entry overrides whatever the state branch scheduled.
      if (w_fault_go) begin
        r_rail_en     <= '0;
        r_level       <= 3'd0;
        r_pwr_fault   <= 1'b1;
        r_fault_rail  <= w_fault_num;
        r_rails_ready <= 1'b0;
        r_roic_rst_n  <= 1'b0;
        r_roic_cnt    <= '0;
        r_state       <= ST_FAULT;
      end
    end
  end

  assign rail_en     = r_rail_en;
  assign rails_ready = r_rails_ready;
  assign roic_rst_n  = r_roic_rst_n;
  assign pwr_fault   = r_pwr_fault;
  assign fault_rail  = r_fault_rail;
  assign level       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pwr_rail_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwr_rail_ctrl
// Brief    : Scoreboard bench for pwr_rail_ctrl with a board power-good model.
// Revision : 1.0
// ============================================================================
module tb_pwr_rail_ctrl;

  logic       fsm_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] steps = '0;
  logic [5:0] pg_in = '0;
  logic       clear_fault = 1'b0;
  logic [5:0] rail_en;
  logic       rails_ready, roic_rst_n, pwr_fault;
  logic [2:0] fault_rail, level;

  always #5 fsm_clk = ~fsm_clk;

  pwr_rail_ctrl #(
    .FILT_CYCLES(4), .DEB_CYCLES(16), .UP_TIMEOUT(1000),
    .DN_TIMEOUT(1000), .ROIC_DLY(64), .CNT_W(24)
  ) dut (
    .fsm_clk(fsm_clk), .rst_n(rst_n),
    .pwr_init_step1(steps[0]), .pwr_init_step2(steps[1]), .pwr_init_step3(steps[2]),
    .pwr_init_step4(steps[3]), .pwr_init_step5(steps[4]), .pwr_init_step6(steps[5]),
    .pg_in(pg_in), .clear_fault(clear_fault),
    .rail_en(rail_en), .rails_ready(rails_ready), .roic_rst_n(roic_rst_n),
    .pwr_fault(pwr_fault), .fault_rail(fault_rail), .level(level)
  );

  // Board: power-good follows each enable a few cycles later unless forced low.
  logic [5:0] pg_pipe [0:4] = '{default: '0};
  logic [5:0] pg_low_force = '0;
  always @(negedge fsm_clk) begin
    for (int i = 4; i > 0; i--) pg_pipe[i] = pg_pipe[i-1];
    pg_pipe[0] = rail_en;
    pg_in = pg_pipe[4] & ~pg_low_force;
  end

  typedef struct packed {
    logic [5:0] en;
    logic [2:0] lvl;
    logic       flt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   m_level = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] thermo(input int n);
    logic [6:0] v;
    v = (7'd1 << n) - 7'd1;
    return v[5:0];
  endfunction

  function automatic int top_step(input logic [5:0] s);
    int t = 0;
    for (int i = 0; i < 6; i++) if (s[i]) t = i + 1;
    return t;
  endfunction

  // Reference: one rail per transaction from the current level to the target.
  task automatic apply_steps(input logic [5:0] s);
    int tgt;
    @(negedge fsm_clk);
    steps = s;
    tgt = top_step(s);
    while (m_level < tgt) begin
      sb_q.push_back('{en: thermo(m_level + 1), lvl: 3'(m_level), flt: 1'b0});
      m_level++;
    end
    while (m_level > tgt) begin
      sb_q.push_back('{en: thermo(m_level - 1), lvl: 3'(m_level), flt: 1'b0});
      m_level--;
    end
  endtask

  task automatic push_fault();
    sb_q.push_back('{en: 6'd0, lvl: 3'd0, flt: 1'b1});
    m_level = 0;
  endtask

  task automatic wait_settle(input string nm);
    int t = 0;
    while ((sb_q.size() != 0 || level != 3'(m_level)) && t < 4000) begin
      @(posedge fsm_clk); #1; t++;
    end
    chk({nm, "_settle_in_time"}, 32'(t < 4000), 32'd1);
    chk({nm, "_level"}, 32'(level), 32'(m_level));
    chk({nm, "_rail_en"}, 32'(rail_en), 32'(thermo(m_level)));
    chk({nm, "_rails_ready"}, 32'(rails_ready), 32'(m_level == 6));
  endtask

  task automatic pulse_clear();
    @(negedge fsm_clk); clear_fault = 1'b1;
    @(negedge fsm_clk); clear_fault = 1'b0;
  endtask

  // Monitor: every rail_en transition must match the next expected transaction.
  initial begin
    logic [5:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge fsm_clk); #1;
      if (rail_en !== prev) begin
        if (mon_en) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_rail_en: got %0h expected %0h", rail_en, prev);
          end else begin
            e = sb_q.pop_front();
            chk("mon_rail_en", 32'(rail_en), 32'(e.en));
            chk("mon_level", 32'(level), 32'(e.lvl));
            chk("mon_pwr_fault", 32'(pwr_fault), 32'(e.flt));
          end
        end
        prev = rail_en;
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(posedge fsm_clk);
    #1;
    chk("rst_rail_en", 32'(rail_en), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_rails_ready", 32'(rails_ready), 0);
    chk("rst_roic_rst_n", 32'(roic_rst_n), 0);
    chk("rst_pwr_fault", 32'(pwr_fault), 0);
    chk("rst_fault_rail", 32'(fault_rail), 0);
    @(negedge fsm_clk); rst_n = 1'b1; mon_en = 1'b1;
    repeat (10) @(negedge fsm_clk);

    // Short step pulse must be filtered out.
    steps = 6'b000100;
    repeat (2) @(negedge fsm_clk);
    steps = 6'b000000;
    repeat (40) @(negedge fsm_clk);
    chk("pulse_rail_en", 32'(rail_en), 0);
    chk("pulse_level", 32'(level), 0);

    // Power-on, one step at a time, with edge-to-enable latency.
    for (int k = 1; k <= 6; k++) begin
      apply_steps(thermo(k));
      t = 0;
      while (rail_en == thermo(k - 1) && t < 50) begin @(posedge fsm_clk); #1; t++; end
      chk("step_latency", 32'(t), 32'd7);
      if (k == 6) begin
        t = 0;
        while (!rails_ready && t < 200) begin @(posedge fsm_clk); #1; t++; end
        chk("rails_ready_rise", 32'(rails_ready), 1);
        chk("roic_low_at_ready", 32'(roic_rst_n), 0);
        t = 0;
        while (!roic_rst_n && t < 200) begin @(posedge fsm_clk); #1; t++; end
        chk("roic_delay", 32'(t), 32'd64);
      end
      wait_settle("power_on");
      repeat (100) @(negedge fsm_clk);
    end
    chk("on_roic_rst_n", 32'(roic_rst_n), 1);
    chk("on_pwr_fault", 32'(pwr_fault), 0);

    // Power-off walk.
    for (int k = 5; k >= 0; k--) begin
      apply_steps(thermo(k));
      if (k == 5) begin
        t = 0;
        while (rail_en == 6'h3F && t < 50) begin @(posedge fsm_clk); #1; t++; end
        chk("off_roic_drop", 32'(roic_rst_n), 0);
        chk("off_ready_drop", 32'(rails_ready), 0);
      end
      wait_settle("power_off");
    end

    // Up timeout on rail 1.
    pg_low_force = 6'b000001;
    apply_steps(6'b000001);
    push_fault();
    t = 0;
    while (rail_en == 6'd0 && t < 50) begin @(posedge fsm_clk); #1; t++; end
    t = 0;
    while (!pwr_fault && t < 1500) begin @(posedge fsm_clk); #1; t++; end
    chk("up_timeout_window", 32'(t >= 995 && t <= 1005), 1);
    chk("up_timeout_rail", 32'(fault_rail), 1);
    chk("up_timeout_en", 32'(rail_en), 0);
    pulse_clear();
    repeat (10) @(negedge fsm_clk);
    chk("clear_ignored", 32'(pwr_fault), 1);
    pg_low_force = '0;
    apply_steps(6'b000000);
    repeat (20) @(negedge fsm_clk);
    pulse_clear();
    repeat (3) @(negedge fsm_clk);
    chk("clear_pwr_fault", 32'(pwr_fault), 0);
    chk("clear_fault_rail", 32'(fault_rail), 0);

    // Power-good glitch while ramping rail 1.
    apply_steps(6'b000001);
    t = 0;
    while (rail_en == 6'd0 && t < 50) begin @(posedge fsm_clk); #1; t++; end
    repeat (9) @(negedge fsm_clk);
    pg_low_force = 6'b000001;
    repeat (8) @(negedge fsm_clk);
    pg_low_force = '0;
    t = 0;
    while (level != 3'd1 && t < 60) begin @(posedge fsm_clk); #1; t++; end
    chk("pg_glitch_confirm_window", 32'(t >= 16 && t <= 20), 1);
    wait_settle("pg_glitch");

    // Two steps at once from level 0.
    apply_steps(6'b000000);
    wait_settle("to_zero");
    apply_steps(6'b010010);
    wait_settle("multi_step");

    // Brownout on rail 3 while fully up.
    apply_steps(6'h3F);
    wait_settle("bo_up");
    repeat (80) @(negedge fsm_clk);
`ifdef PWR_BROWNOUT_MON_EN
    push_fault();
    pg_low_force = 6'b000100;
    repeat (20) @(negedge fsm_clk);
    pg_low_force = '0;
    t = 0;
    while (!pwr_fault && t < 100) begin @(posedge fsm_clk); #1; t++; end
    chk("bo_fault", 32'(pwr_fault), 1);
    chk("bo_fault_rail", 32'(fault_rail), 3);
    apply_steps(6'b000000);
    repeat (20) @(negedge fsm_clk);
    pulse_clear();
    repeat (3) @(negedge fsm_clk);
    chk("bo_clear", 32'(pwr_fault), 0);
`else
    pg_low_force = 6'b000100;
    repeat (20) @(negedge fsm_clk);
    pg_low_force = '0;
    repeat (30) @(negedge fsm_clk);
    chk("no_bo_level", 32'(level), 6);
    chk("no_bo_fault", 32'(pwr_fault), 0);
    chk("no_bo_rail_en", 32'(rail_en), 32'h3F);
`endif

    // Randomized step patterns.
    for (int i = 0; i < 20; i++) begin
      apply_steps(6'($urandom_range(0, 63)));
      wait_settle("rand");
    end

    // Asynchronous reset mid-ramp.
    apply_steps(6'b000000);
    wait_settle("pre_reset");
    apply_steps(6'h3F);
    t = 0;
    while (level != 3'd2 && t < 500) begin @(posedge fsm_clk); #1; t++; end
    @(negedge fsm_clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rail_en", 32'(rail_en), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_ready", 32'(rails_ready), 0);
    chk("mid_rst_roic", 32'(roic_rst_n), 0);
    chk("mid_rst_fault", 32'(pwr_fault), 0);
    sb_q.delete();
    m_level = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwr_rail_ctrl.md
Name: pwr_rail_ctrl

Overview:
- Responder side of the power-init step handshake: consumes the six pwr_init_step levels from the init sequencer, drives one enable per rail, confirms each rail via its power-good input, and reports ready/fault status.
- Moves one rail at a time toward the requested level, in both the ascending (power-on) and descending (power-off) directions.
- Gates the ROIC reset release on full rail confirmation.
- Sits between the init sequencer and the board PMIC/LDO enable pins.

Parameters:
- FILT_CYCLES, 4: consecutive identical samples required before the step target is accepted.
- DEB_CYCLES, 16: consecutive cycles a power-good level must hold to be accepted.
- UP_TIMEOUT, 1000000: cycles allowed for pg high after a rail enable.
- DN_TIMEOUT, 1000000: cycles allowed for pg low after a rail disable.
- ROIC_DLY, 64: cycles from rails_ready to roic_rst_n release.
- CNT_W, 24: width of the timeout/delay counter; must hold max(UP_TIMEOUT, DN_TIMEOUT, ROIC_DLY).

Ports:
- fsm_clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- pwr_init_step1..pwr_init_step6  in  1 each  step levels from the sequencer
- pg_in  in  6  asynchronous power-good, bit k = rail k+1
- clear_fault  in  1  single-cycle fault clear
- rail_en  out  6  rail enables, bit k = rail k+1
- rails_ready  out  1  all 6 rails enabled and confirmed
- roic_rst_n  out  1  ROIC reset, active-low
- pwr_fault  out  1  sticky fault flag
- fault_rail  out  3  rail number 1..6 that faulted, 0 = none
- level  out  3  number of confirmed enabled rails, 0..6

Behaviour:
- Reset (async): rail_en=0, rails_ready=0, roic_rst_n=0, pwr_fault=0, fault_rail=0, level=0, state=STABLE, target=0, counters=0.
- Input sync: steps and pg_in each pass through 2-flop synchronizers.
- Target: index of the highest asserted synced step, 0 if none (multiple asserted → highest wins). The target register updates only after FILT_CYCLES consecutive identical samples.
- Target latency: a clean step edge reaches rail_en in exactly FILT_CYCLES+3 cycles.
- STABLE:
  - target>level → set rail_en[level], clear counter, go RAMP_UP.
  - target<level → clear rail_en[level-1], clear counter, go RAMP_DN.
  - target==level → hold.
- RAMP_UP:
  - pg_in[level] high for DEB_CYCLES consecutive cycles → level+1, go STABLE.
  - Counter reaches UP_TIMEOUT first → go FAULT, fault_rail=level+1.
  - Target changes during RAMP_UP are ignored until the state completes.
- RAMP_DN:
  - pg_in[level-1] low for DEB_CYCLES consecutive cycles → level-1, go STABLE.
  - Counter reaches DN_TIMEOUT first → go FAULT, fault_rail=level.
  - Target changes during RAMP_DN are ignored until the state completes.
- Debounce: a glitch resets the debounce count but not the timeout counter.
- FAULT:
  - Same cycle as entry: rail_en=0, level=0, pwr_fault=1, rails_ready=0, roic_rst_n=0.
  - Exit only on clear_fault==1 with target==0 → pwr_fault=0, fault_rail=0, go STABLE.
  - clear_fault with target!=0 is ignored.
- rails_ready = (state==STABLE && level==6), registered.
- roic_rst_n:
  - Rises ROIC_DLY cycles after rails_ready rises.
  - Falls in the same cycle rails_ready falls.
  - The delay count restarts if rails_ready drops mid-delay.
- Only one rail changes per transaction; rail_en is always a thermometer code (bits 0..level-1 set, plus the in-flight bit).
- Reset asserted mid-ramp forces all outputs to reset values immediately.

Optional Feature:
- Macro: PWR_BROWNOUT_MON_EN.
- Defined: in STABLE, any enabled rail whose synced pg is low for DEB_CYCLES consecutive cycles → FAULT with fault_rail = lowest such rail number.
- Not defined: pg is examined only in RAMP_UP/RAMP_DN, and pg drops in STABLE are ignored.

Test Plan:
- Power-on: steps 1..6 asserted in order, each held 200 cycles, pg follows rail_en after 5 cycles → level 6, rail_en=6'h3F, rails_ready=1, roic_rst_n rises 64 cycles later, pwr_fault=0.
- Power-off: from level 6, target walked 5..0 with pg following → rails disabled in order 6→1, level=0, rail_en=0, roic_rst_n=0 on the first disable.
- Up timeout: step1 asserted, pg_in[0] held low, UP_TIMEOUT=1000 → FAULT at ~1000 cycles after enable, fault_rail=1, rail_en=0. clear_fault with target=1 ignored; after target=0, clear_fault → pwr_fault=0.
- Glitch filtering: step3 pulse of 2 cycles (< FILT_CYCLES=4) → no rail_en change. pg glitch of 8 cycles during RAMP_UP → debounce restarts and rail confirms 16 cycles after the glitch ends.
- Multi-step: step2 and step5 asserted together from level 0 → rails 1..5 ramp sequentially, level=5.
- Brownout (macro on): level 6 stable, pg_in[2] low for 20 cycles → FAULT, fault_rail=3. Macro off → no fault, level stays 6.
